orientation_scheduler: RTL and testbench
========================================

// Module: orientation_scheduler
// PURPOSE
// - Sequences gradient_orientation over a stream of keypoints: accepts one keypoint, launches the engine, collects its bin, emits a result.
// - Shares one gradient BRAM read port between the engine's x and y read channels (bank bit selects x/y) via round-robin.
// - Sits between keypoint detection and descriptor generation.
// PARAMETERS
// - WIDTH         64   image width in pixels
// - HEIGHT        64   image height in pixels
// - BIT_DEPTH     8    gradient sample width
// - NUM_BINS      8    orientation bins; BIN_W = $clog2(NUM_BINS)
// - BRAM_LATENCY  2    grant-to-data cycles of gradient BRAM (>=1)
// - TIMEOUT       1023 max WAIT cycles (ORIENT_TIMEOUT_EN only)
// PORTS  (XW=$clog2(WIDTH), YW=$clog2(HEIGHT), AW=$clog2(WIDTH*HEIGHT))
// - clk_in            in   1          system clock
// - rst_n_in          in   1          async active-low reset
// - kp_x_in/kp_y_in   in   XW/YW      keypoint coords
// - kp_valid_in       in   1          keypoint valid
// - kp_ready_out      out  1          keypoint accepted when valid&ready
// - eng_center_x_out/eng_center_y_out out XW/YW  latched centre to engine
// - eng_valid_out     out  1          1-cycle engine start pulse
// - eng_x_read_addr_in/eng_y_read_addr_in  in AW  engine read addresses
// - eng_x_read_addr_valid_in/eng_y_..._in  in 1   read requests
// - eng_x_read_ready_out/eng_y_read_ready_out out 1  request granted this cycle
// - eng_x_pixel_out/eng_y_pixel_out  out BIT_DEPTH  returned sample (held)
// - eng_x_pixel_valid_out/eng_y_..._out out 1  1-cycle return strobe
// - eng_valid_in      in   1          engine done
// - eng_bin_in        in   BIN_W      engine bin
// - mem_addr_out      out  AW+1       {bank(0=x,1=y), addr}
// - mem_en_out        out  1          read strobe
// - mem_data_in       in   BIT_DEPTH  BRAM data, BRAM_LATENCY after mem_en_out
// - res_x_out/res_y_out/res_bin_out out XW/YW/BIN_W  result
// - res_border_out    out  1          keypoint on image border, engine skipped
// - res_timeout_out   out  1          engine timed out
// - res_valid_out     out  1          result valid; held until res_ready_in
// - res_ready_in      in   1          result consumer ready
// BEHAVIOUR
// - Reset: all registered outputs 0, state IDLE, RR pointer = x, tag pipeline cleared; kp_ready_out = (state==IDLE), comb.
// - FSM: IDLE -kp handshake-> ISSUE (latch coords) or OUTPUT if x==0|x==WIDTH-1|y==0|y==HEIGHT-1 (bin 0, border=1).
// - ISSUE: eng_valid_out=1 one cycle with latched centre -> WAIT.
// - WAIT: arbiter live; eng_valid_in captures eng_bin_in -> OUTPUT. eng_valid_in outside WAIT ignored.
// - OUTPUT: res_* stable, res_valid_out=1 until res_ready_in -> IDLE. Min keypoint-to-keypoint: 4 cycles.
// - Arbiter (WAIT only; ready=0 elsewhere): one grant/cycle; single requester always granted; both -> RR pointer side, pointer flips after each contested grant. Loser holds request.
// - Grant: mem_en_out=1, mem_addr_out={bank,addr} same cycle (comb from requests+pointer); tag shifts through BRAM_LATENCY-deep pipe.
// - Return: tag selects x or y pixel reg; pixel_valid strobes 1 cycle; pixel held until next same-channel return. Returns complete even after leaving WAIT.
// - Addresses forwarded unchecked; engine owns range.
// - Reset mid-operation: FSM to IDLE, in-flight reads discarded, no strobes.
// CONFIGURATION
// - ORIENT_TIMEOUT_EN defined: WAIT counter; at TIMEOUT cycles without eng_valid_in -> OUTPUT with bin NUM_BINS-1, res_timeout_out=1; late eng_valid_in ignored.
// - Undefined: no counter, WAIT indefinitely, res_timeout_out tied 0.
// TESTING  (WIDTH=HEIGHT=8, BRAM_LATENCY=2)
// - kp (3,4), engine model reads 9+9 samples, returns bin 5 -> one eng_valid_out with centre (3,4); res (3,4,5), border=0.
// - x and y request same cycle, 4 cycles -> grants alternate x,y,x,y; mem_addr_out MSB 0,1,0,1; data strobes 2 cycles after each grant.
// - kp (0,5) -> no eng_valid_out, no mem_en_out; res bin 0, border=1 on 2nd cycle after accept.
// - res_ready_in low 10 cycles -> res_* stable, kp_ready_out=0 throughout; next kp accepted cycle after ready.
// - rst_n_in low one cycle in WAIT with 2 reads in flight -> no pixel_valid strobes afterwards, kp_ready_out=1.
// - ORIENT_TIMEOUT_EN, TIMEOUT=20, engine silent -> res bin 7, timeout=1 after 20 WAIT cycles.

Source files
------------

// File: rtl/orientation_scheduler.sv
// Keypoint sequencer for the gradient_orientation engine, with a round-robin shared gradient BRAM read port.
// Optional build macro: ORIENT_TIMEOUT_EN adds a WAIT-state watchdog that forces a timeout result.
module orientation_scheduler #(
    parameter int WIDTH        = 64,
    parameter int HEIGHT       = 64,
    parameter int BIT_DEPTH    = 8,
    parameter int NUM_BINS     = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int TIMEOUT      = 1023,
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(HEIGHT),
    localparam int AW    = $clog2(WIDTH * HEIGHT),
    localparam int BIN_W = $clog2(NUM_BINS)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [XW-1:0]        kp_x_in,
    input  logic [YW-1:0]        kp_y_in,
    input  logic                 kp_valid_in,
    output logic                 kp_ready_out,
    output logic [XW-1:0]        eng_center_x_out,
    output logic [YW-1:0]        eng_center_y_out,
    output logic                 eng_valid_out,
    input  logic [AW-1:0]        eng_x_read_addr_in,
    input  logic [AW-1:0]        eng_y_read_addr_in,
    input  logic                 eng_x_read_addr_valid_in,
    input  logic                 eng_y_read_addr_valid_in,
    output logic                 eng_x_read_ready_out,
    output logic                 eng_y_read_ready_out,
    output logic [BIT_DEPTH-1:0] eng_x_pixel_out,
    output logic [BIT_DEPTH-1:0] eng_y_pixel_out,
    output logic                 eng_x_pixel_valid_out,
    output logic                 eng_y_pixel_valid_out,
    input  logic                 eng_valid_in,
    input  logic [BIN_W-1:0]     eng_bin_in,
    output logic [AW:0]          mem_addr_out,
    output logic                 mem_en_out,
    input  logic [BIT_DEPTH-1:0] mem_data_in,
    output logic [XW-1:0]        res_x_out,
    output logic [YW-1:0]        res_y_out,
    output logic [BIN_W-1:0]     res_bin_out,
    output logic                 res_border_out,
    output logic                 res_timeout_out,
    output logic                 res_valid_out,
    input  logic                 res_ready_in
);

    if (TIMEOUT < 1 || BRAM_LATENCY < 1) begin : g_bad_cfg
        $error("orientation_scheduler: TIMEOUT and BRAM_LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t                  state;
    logic                    rr_ptr;        // 0 = x wins the next contested cycle
    logic [BRAM_LATENCY-1:0] tag_valid;
    logic [BRAM_LATENCY-1:0] tag_bank;
    logic [BIT_DEPTH-1:0]    x_hold;
    logic [BIT_DEPTH-1:0]    y_hold;

    logic in_wait, contested, grant_x, grant_y, on_border;
    logic ret_x, ret_y;

    assign kp_ready_out = (state == S_IDLE);

    assign on_border = (kp_x_in == '0) || (kp_x_in == XW'(WIDTH - 1)) ||
                       (kp_y_in == '0) || (kp_y_in == YW'(HEIGHT - 1));

    // NOTE: grants are continuous assigns rather than an always block, so no partial-assignment latch can appear.
    assign in_wait   = (state == S_WAIT);
    assign contested = in_wait && eng_x_read_addr_valid_in && eng_y_read_addr_valid_in;
    assign grant_x   = in_wait && eng_x_read_addr_valid_in && (!eng_y_read_addr_valid_in || !rr_ptr);
    assign grant_y   = in_wait && eng_y_read_addr_valid_in && (!eng_x_read_addr_valid_in || rr_ptr);

    assign eng_x_read_ready_out = grant_x;
    assign eng_y_read_ready_out = grant_y;
    assign mem_en_out           = grant_x || grant_y;
    assign mem_addr_out         = {grant_y, grant_y ? eng_y_read_addr_in : eng_x_read_addr_in};

    // Returned data is forwarded in its arrival cycle and held afterwards.
    assign ret_x = tag_valid[BRAM_LATENCY-1] && !tag_bank[BRAM_LATENCY-1];
    assign ret_y = tag_valid[BRAM_LATENCY-1] &&  tag_bank[BRAM_LATENCY-1];

    assign eng_x_pixel_valid_out = ret_x;
    assign eng_y_pixel_valid_out = ret_y;
    assign eng_x_pixel_out       = ret_x ? mem_data_in : x_hold;
    assign eng_y_pixel_out       = ret_y ? mem_data_in : y_hold;

    // NOTE: the tag pipe sits under the async reset so reads in flight at reset can never strobe afterwards.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr    <= 1'b0;
            tag_valid <= '0;
            tag_bank  <= '0;
            x_hold    <= '0;
            y_hold    <= '0;
        end else begin
            if (contested) rr_ptr <= !rr_ptr;
            tag_valid[0] <= mem_en_out;
            tag_bank[0]  <= grant_y;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_bank[i]  <= tag_bank[i-1];
            end
            if (ret_x) x_hold <= mem_data_in;
            if (ret_y) y_hold <= mem_data_in;
        end
    end

`ifdef ORIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_q;
    assign res_timeout_out = timeout_q;
`else
    assign res_timeout_out = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= S_IDLE;
            eng_center_x_out <= '0;
            eng_center_y_out <= '0;
            eng_valid_out    <= 1'b0;
            res_x_out        <= '0;
            res_y_out        <= '0;
            res_bin_out      <= '0;
            res_border_out   <= 1'b0;
            res_valid_out    <= 1'b0;
`ifdef ORIENT_TIMEOUT_EN
            wait_cnt         <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (kp_valid_in) begin
                        eng_center_x_out <= kp_x_in;
                        eng_center_y_out <= kp_y_in;
                        res_x_out        <= kp_x_in;
                        res_y_out        <= kp_y_in;
`ifdef ORIENT_TIMEOUT_EN
                        timeout_q        <= 1'b0;
`endif
                        if (on_border) begin
                            res_bin_out    <= '0;
                            res_border_out <= 1'b1;
                            res_valid_out  <= 1'b1;
                            state          <= S_OUTPUT;
                        end else begin
                            res_border_out <= 1'b0;
                            eng_valid_out  <= 1'b1;
                            state          <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    eng_valid_out <= 1'b0;
`ifdef ORIENT_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_valid_in) begin
                        res_bin_out   <= eng_bin_in;
                        res_valid_out <= 1'b1;
                        state         <= S_OUTPUT;
`ifdef ORIENT_TIMEOUT_EN
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        res_bin_out   <= BIN_W'(NUM_BINS - 1);
                        timeout_q     <= 1'b1;
                        res_valid_out <= 1'b1;
                        state         <= S_OUTPUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_OUTPUT: begin
                    if (res_ready_in) begin
                        res_valid_out <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_orientation_scheduler.sv
// Self-checking bench for orientation_scheduler: randomized engine/BRAM traffic against a queue-based reference.
// Define ORIENT_TIMEOUT_EN to build and check the watchdog variant (TIMEOUT=20).
`timescale 1ns/1ps
module tb_orientation_scheduler;

    localparam int WIDTH = 8, HEIGHT = 8, BIT_DEPTH = 8, NUM_BINS = 8, LAT = 2;
`ifdef ORIENT_TIMEOUT_EN
    localparam int TIMEOUT = 20;
    localparam int N_RD    = 4;
`else
    localparam int TIMEOUT = 1023;
    localparam int N_RD    = 9;
`endif
    localparam int XW = $clog2(WIDTH), YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT), BIN_W = $clog2(NUM_BINS);

    logic clk_in = 1'b0, rst_n_in;
    logic [XW-1:0] kp_x_in, eng_center_x_out, res_x_out;
    logic [YW-1:0] kp_y_in, eng_center_y_out, res_y_out;
    logic kp_valid_in, kp_ready_out, eng_valid_out;
    logic [AW-1:0] eng_x_read_addr_in, eng_y_read_addr_in;
    logic eng_x_read_addr_valid_in, eng_y_read_addr_valid_in;
    logic eng_x_read_ready_out, eng_y_read_ready_out;
    logic [BIT_DEPTH-1:0] eng_x_pixel_out, eng_y_pixel_out, mem_data_in;
    logic eng_x_pixel_valid_out, eng_y_pixel_valid_out, eng_valid_in;
    logic [BIN_W-1:0] eng_bin_in, res_bin_out;
    logic [AW:0] mem_addr_out;
    logic mem_en_out, res_border_out, res_timeout_out, res_valid_out, res_ready_in;

    orientation_scheduler #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_DEPTH(BIT_DEPTH), .NUM_BINS(NUM_BINS),
        .BRAM_LATENCY(LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .kp_x_in(kp_x_in), .kp_y_in(kp_y_in), .kp_valid_in(kp_valid_in), .kp_ready_out(kp_ready_out),
        .eng_center_x_out(eng_center_x_out), .eng_center_y_out(eng_center_y_out), .eng_valid_out(eng_valid_out),
        .eng_x_read_addr_in(eng_x_read_addr_in), .eng_y_read_addr_in(eng_y_read_addr_in),
        .eng_x_read_addr_valid_in(eng_x_read_addr_valid_in), .eng_y_read_addr_valid_in(eng_y_read_addr_valid_in),
        .eng_x_read_ready_out(eng_x_read_ready_out), .eng_y_read_ready_out(eng_y_read_ready_out),
        .eng_x_pixel_out(eng_x_pixel_out), .eng_y_pixel_out(eng_y_pixel_out),
        .eng_x_pixel_valid_out(eng_x_pixel_valid_out), .eng_y_pixel_valid_out(eng_y_pixel_valid_out),
        .eng_valid_in(eng_valid_in), .eng_bin_in(eng_bin_in),
        .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_data_in(mem_data_in),
        .res_x_out(res_x_out), .res_y_out(res_y_out), .res_bin_out(res_bin_out),
        .res_border_out(res_border_out), .res_timeout_out(res_timeout_out),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Gradient BRAM: address registered LAT times, data visible LAT cycles after the strobe.
    logic [BIT_DEPTH-1:0] gmem [0:2*WIDTH*HEIGHT-1];
    logic [AW:0] rd_pipe [0:LAT-1];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem_addr_out;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_in = gmem[rd_pipe[LAT-1]];

    typedef struct {int due; logic [BIT_DEPTH-1:0] d;} ret_t;
    ret_t qx[$], qy[$];
    bit   grant_log[$];
    bit   rr;
    logic [BIT_DEPTH-1:0] last_x, last_y;
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;

    function automatic logic [AW-1:0] nb_addr(input int cx, input int cy, input int i);
        return AW'((cy + i / 3 - 1) * WIDTH + cx + i % 3 - 1);
    endfunction

    function automatic bit want_req(input bit contend);
`ifdef ORIENT_TIMEOUT_EN
        return 1'b1;
`else
        return contend || ($urandom % 3 != 0);
`endif
    endfunction

    task automatic drive_idle();
        kp_x_in = '0; kp_y_in = '0; kp_valid_in = 1'b0;
        eng_x_read_addr_in = '0; eng_y_read_addr_in = '0;
        eng_x_read_addr_valid_in = 1'b0; eng_y_read_addr_valid_in = 1'b0;
        eng_valid_in = 1'b0; eng_bin_in = '0; res_ready_in = 1'b0;
    endtask

    task automatic model_reset();
        rr = 1'b0; last_x = '0; last_y = '0;
        qx.delete(); qy.delete();
    endtask

    // One keypoint through ISSUE/WAIT/OUTPUT with an engine that reads a 3x3 neighbourhood per channel.
    task automatic run_kp(input int cx, input int cy, input int bin, input bit contend, input int stall);
        int xi, yi, guard;
        bit xr, yr, gx, gy, ex, ey;
        logic [AW-1:0] xa, ya;
        logic [XW+YW+BIN_W+3:0] got, expv;
        ret_t r;
        @(negedge clk_in);
        kp_x_in = XW'(cx); kp_y_in = YW'(cy); kp_valid_in = 1'b1;
        #1;
        n_checks++;
        if (kp_ready_out !== 1'b1) begin n_fail++; $display("FAIL kp_ready_idle: got %b want 1", kp_ready_out); end
        xi = 0; yi = 0; xr = contend; yr = contend;
        xa = nb_addr(cx, cy, 0); ya = xa;
        @(negedge clk_in);
        kp_valid_in = 1'b0;
        eng_x_read_addr_valid_in = xr; eng_y_read_addr_valid_in = yr;
        eng_x_read_addr_in = xa; eng_y_read_addr_in = ya;
        #1;
        n_checks++;
        if (eng_valid_out !== 1'b1 || eng_center_x_out !== XW'(cx) || eng_center_y_out !== YW'(cy)) begin
            n_fail++;
            $display("FAIL issue: got v=%b c=(%0d,%0d) want v=1 c=(%0d,%0d)", eng_valid_out, eng_center_x_out, eng_center_y_out, cx, cy);
        end
        n_checks++;
        if ({eng_x_read_ready_out, eng_y_read_ready_out, mem_en_out} !== 3'b000) begin
            n_fail++; $display("FAIL grant_outside_wait: got %b%b%b want 000", eng_x_read_ready_out, eng_y_read_ready_out, mem_en_out);
        end
        guard = 0;
        while ((xi < N_RD || yi < N_RD || qx.size() > 0 || qy.size() > 0) && guard < 200) begin
            @(negedge clk_in);
            cyc++; guard++;
            if (!xr && xi < N_RD) xr = want_req(contend);
            if (!yr && yi < N_RD) yr = want_req(contend);
            xa = nb_addr(cx, cy, xi); ya = nb_addr(cx, cy, yi);
            eng_x_read_addr_valid_in = xr; eng_y_read_addr_valid_in = yr;
            eng_x_read_addr_in = xa; eng_y_read_addr_in = ya;
            #1;
            gx = xr && (!yr || !rr);
            gy = yr && (!xr || rr);
            n_checks++;
            if ({eng_x_read_ready_out, eng_y_read_ready_out, mem_en_out} !== {gx, gy, gx | gy}) begin
                n_fail++;
                $display("FAIL grant: got x=%b y=%b en=%b want x=%b y=%b en=%b", eng_x_read_ready_out, eng_y_read_ready_out, mem_en_out, gx, gy, gx | gy);
            end
            if (gx || gy) begin
                n_checks++;
                if (mem_addr_out !== (gy ? {1'b1, ya} : {1'b0, xa})) begin
                    n_fail++; $display("FAIL mem_addr: got %h want %h", mem_addr_out, gy ? {1'b1, ya} : {1'b0, xa});
                end
            end
            if (mem_en_out) grant_log.push_back(mem_addr_out[AW]);
            ex = qx.size() > 0 && qx[0].due == cyc;
            ey = qy.size() > 0 && qy[0].due == cyc;
            if (ex) begin last_x = qx[0].d; void'(qx.pop_front()); end
            if (ey) begin last_y = qy[0].d; void'(qy.pop_front()); end
            n_checks++;
            if (eng_x_pixel_valid_out !== ex || eng_x_pixel_out !== last_x) begin
                n_fail++; $display("FAIL x_return: got v=%b d=%h want v=%b d=%h", eng_x_pixel_valid_out, eng_x_pixel_out, ex, last_x);
            end
            n_checks++;
            if (eng_y_pixel_valid_out !== ey || eng_y_pixel_out !== last_y) begin
                n_fail++; $display("FAIL y_return: got v=%b d=%h want v=%b d=%h", eng_y_pixel_valid_out, eng_y_pixel_out, ey, last_y);
            end
            n_checks++;
            if (eng_valid_out !== 1'b0 || res_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL wait_quiet: got eng_valid=%b res_valid=%b want 0 0", eng_valid_out, res_valid_out);
            end
            if (xr && yr) rr = !rr;
            if (gx) begin r.due = cyc + LAT; r.d = gmem[{1'b0, xa}]; qx.push_back(r); xi++; xr = 1'b0; end
            if (gy) begin r.due = cyc + LAT; r.d = gmem[{1'b1, ya}]; qy.push_back(r); yi++; yr = 1'b0; end
        end
        if (guard >= 200) begin
            n_checks++; n_fail++; $display("FAIL engine_budget: got %0d cycles want < 200", guard);
            qx.delete(); qy.delete();
        end
        @(negedge clk_in);
        eng_x_read_addr_valid_in = 1'b0; eng_y_read_addr_valid_in = 1'b0;
        eng_valid_in = 1'b1; eng_bin_in = BIN_W'(bin);
        #1;
        n_checks++;
        if (res_valid_out !== 1'b0) begin n_fail++; $display("FAIL res_early: got %b want 0", res_valid_out); end
        expv = {1'b1, XW'(cx), YW'(cy), BIN_W'(bin), 3'b000};
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk_in);
            eng_valid_in = (i == 0) ? 1'b0 : 1'($urandom);
            eng_bin_in = BIN_W'($urandom);
            kp_valid_in = (i != 0);
            kp_x_in = XW'($urandom); kp_y_in = YW'($urandom);
            res_ready_in = (i == stall);
            #1;
            got = {res_valid_out, res_x_out, res_y_out, res_bin_out, res_border_out, res_timeout_out, kp_ready_out};
            n_checks++;
            if (got !== expv) begin
                n_fail++; $display("FAIL result_hold[%0d]: got %h want %h (valid,x,y,bin,border,timeout,kp_ready)", i, got, expv);
            end
        end
        @(negedge clk_in);
        res_ready_in = 1'b0; kp_valid_in = 1'b0; eng_valid_in = 1'b0;
        #1;
        n_checks++;
        if (kp_ready_out !== 1'b1 || res_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL release: got kp_ready=%b res_valid=%b want 1 0", kp_ready_out, res_valid_out);
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk_in);
        #1;
        n_checks++;
        if (kp_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_kp_ready: got %b want 1", kp_ready_out); end
        n_checks++;
        if ({eng_valid_out, res_valid_out, res_border_out, res_timeout_out, mem_en_out,
             eng_x_pixel_valid_out, eng_y_pixel_valid_out} !== 7'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b%b%b%b%b%b%b want 0000000", eng_valid_out, res_valid_out,
                               res_border_out, res_timeout_out, mem_en_out, eng_x_pixel_valid_out, eng_y_pixel_valid_out);
        end
        n_checks++;
        if ({res_x_out, res_y_out, res_bin_out, eng_center_x_out, eng_center_y_out, eng_x_pixel_out, eng_y_pixel_out} !== '0) begin
            n_fail++; $display("FAIL reset_values: got res=(%0d,%0d,%0d) ctr=(%0d,%0d) px=%h py=%h want all 0", res_x_out,
                               res_y_out, res_bin_out, eng_center_x_out, eng_center_y_out, eng_x_pixel_out, eng_y_pixel_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        grant_log.delete();
        run_kp(2, 2, 3, 1'b1, 0);
        n_checks++;
        if (grant_log.size() < 4) begin
            n_fail++; $display("FAIL rr_order_len: got %0d grants want >= 4", grant_log.size());
        end else if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 4'b0101) begin
            n_fail++; $display("FAIL rr_order: got banks %b%b%b%b want 0101", grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
        end
    endtask

    task automatic test_main();
        run_kp(3, 4, 5, 1'b0, 0);
        for (int k = 0; k < 4; k++)
            run_kp(1 + int'($urandom % (WIDTH - 2)), 1 + int'($urandom % (HEIGHT - 2)),
                   int'($urandom % NUM_BINS), 1'b0, int'($urandom % 3));
    endtask

    task automatic test_border();
        int bx[4], by[4];
        bx = '{0, WIDTH - 1, 4, 2};
        by = '{5, 3, 0, HEIGHT - 1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            kp_x_in = XW'(bx[i]); kp_y_in = YW'(by[i]); kp_valid_in = 1'b1;
            eng_x_read_addr_valid_in = 1'b1; eng_y_read_addr_valid_in = 1'b1;
            #1;
            n_checks++;
            if (kp_ready_out !== 1'b1) begin n_fail++; $display("FAIL border_accept: got %b want 1", kp_ready_out); end
            @(negedge clk_in);
            kp_valid_in = 1'b0; res_ready_in = 1'b1;
            #1;
            n_checks++;
            if ({res_valid_out, res_x_out, res_y_out, res_bin_out, res_border_out, res_timeout_out, eng_valid_out, mem_en_out}
                !== {1'b1, XW'(bx[i]), YW'(by[i]), BIN_W'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL border_result: got v=%b (%0d,%0d) bin=%0d b=%b t=%b eng=%b en=%b want v=1 (%0d,%0d) bin=0 b=1 t=0 eng=0 en=0",
                                   res_valid_out, res_x_out, res_y_out, res_bin_out, res_border_out, res_timeout_out,
                                   eng_valid_out, mem_en_out, bx[i], by[i]);
            end
            @(negedge clk_in);
            res_ready_in = 1'b0;
            eng_x_read_addr_valid_in = 1'b0; eng_y_read_addr_valid_in = 1'b0;
            #1;
            n_checks++;
            if (kp_ready_out !== 1'b1 || eng_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL border_release: got kp_ready=%b eng_valid=%b want 1 0", kp_ready_out, eng_valid_out);
            end
        end
    endtask

    task automatic test_backpressure();
        run_kp(5, 5, int'($urandom % NUM_BINS), 1'b0, 10);
    endtask

    task automatic test_reset_midop();
        int bad;
        @(negedge clk_in);
        kp_x_in = XW'(2); kp_y_in = YW'(3); kp_valid_in = 1'b1;
        @(negedge clk_in);
        kp_valid_in = 1'b0;
        eng_x_read_addr_in = nb_addr(2, 3, 0); eng_y_read_addr_in = nb_addr(2, 3, 1);
        eng_x_read_addr_valid_in = 1'b1; eng_y_read_addr_valid_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            #1;
            n_checks++;
            if (mem_en_out !== 1'b1) begin n_fail++; $display("FAIL midop_grant[%0d]: got %b want 1", i, mem_en_out); end
        end
        @(negedge clk_in);
        eng_x_read_addr_valid_in = 1'b0; eng_y_read_addr_valid_in = 1'b0;
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            #1;
            if (eng_x_pixel_valid_out !== 1'b0 || eng_y_pixel_valid_out !== 1'b0 || kp_ready_out !== 1'b1 ||
                res_valid_out !== 1'b0 || eng_x_pixel_out !== '0 || eng_y_pixel_out !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_midop: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk_in);
        kp_x_in = XW'(4); kp_y_in = YW'(4); kp_valid_in = 1'b1;
        @(negedge clk_in);
        kp_valid_in = 1'b0;
`ifdef ORIENT_TIMEOUT_EN
        n = 0;
        while (n < 60) begin
            @(negedge clk_in);
            #1;
            if (res_valid_out === 1'b1) break;
            n++;
        end
        n_checks++;
        if (n != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT); end
        n_checks++;
        if ({res_bin_out, res_timeout_out, res_border_out} !== {BIN_W'(NUM_BINS - 1), 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL timeout_result: got bin=%0d t=%b b=%b want bin=%0d t=1 b=0", res_bin_out, res_timeout_out, res_border_out, NUM_BINS - 1);
        end
        @(negedge clk_in);
        eng_valid_in = 1'b1; eng_bin_in = BIN_W'(2);
        #1;
        n_checks++;
        if (res_bin_out !== BIN_W'(NUM_BINS - 1)) begin n_fail++; $display("FAIL late_engine: got bin=%0d want %0d", res_bin_out, NUM_BINS - 1); end
        @(negedge clk_in);
        eng_valid_in = 1'b0; res_ready_in = 1'b1;
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            #1;
            if (res_valid_out !== 1'b0 || kp_ready_out !== 1'b0) n++;
        end
        n_checks++;
        if (n != 0) begin n_fail++; $display("FAIL no_timeout_wait: got %0d bad cycles want 0", n); end
        @(negedge clk_in);
        eng_valid_in = 1'b1; eng_bin_in = BIN_W'(6);
        @(negedge clk_in);
        eng_valid_in = 1'b0;
        #1;
        n_checks++;
        if ({res_valid_out, res_bin_out, res_timeout_out} !== {1'b1, BIN_W'(6), 1'b0}) begin
            n_fail++; $display("FAIL late_done: got v=%b bin=%0d t=%b want v=1 bin=6 t=0", res_valid_out, res_bin_out, res_timeout_out);
        end
        res_ready_in = 1'b1;
`endif
        @(negedge clk_in);
        res_ready_in = 1'b0;
        #1;
        n_checks++;
        if (kp_ready_out !== 1'b1) begin n_fail++; $display("FAIL timeout_release: got %b want 1", kp_ready_out); end
    endtask

    initial begin
        for (int i = 0; i < 2 * WIDTH * HEIGHT; i++) gmem[i] = BIT_DEPTH'($urandom);
        test_reset();
        test_contention();
        test_main();
        test_border();
        test_backpressure();
        test_reset_midop();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
